// File: rtl/seq_detect_pkg.sv
// Shared helpers for serial pattern detectors: prefix-length (KMP) transition
// functions evaluated at elaboration time by each detector instance.
package seq_detect_pkg;

  localparam int SEQ_MAX_N = 16;

  typedef logic [SEQ_MAX_N-1:0] seq_pattern_t;

  // What happened on a clock edge; drives the match pulse and counter.
  typedef enum logic [1:0] {
    SEQ_EV_HOLD,
    SEQ_EV_STEP,
    SEQ_EV_MATCH,
    SEQ_EV_CLEAR
  } seq_event_e;

  function automatic logic seq_bit(input seq_pattern_t pattern, input int idx);
    seq_pattern_t t;
    t = pattern >> idx;
    return t[0];
  endfunction

  // Bit i of the pattern in reception order (i = 0 is the first bit received).
  function automatic logic seq_prefix_bit(input seq_pattern_t pattern, input int n,
                                          input int i);
    return seq_bit(pattern, n - 1 - i);
  endfunction

  // Longest proper prefix of prefix(k) that is also a suffix of prefix(k).
  function automatic int seq_failure(input seq_pattern_t pattern, input int n,
                                     input int k);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < SEQ_MAX_N; j++) begin
      if (j < k) begin
        ok = 1'b1;
        for (int i = 0; i < SEQ_MAX_N; i++) begin
          if (i < j &&
              seq_prefix_bit(pattern, n, i) != seq_prefix_bit(pattern, n, k - j + i))
            ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Prefix length after consuming in_bit while holding prefix length k.
  function automatic int seq_next_state(input seq_pattern_t pattern, input int n,
                                        input int k, input logic in_bit,
                                        input bit overlap);
    int   result;
    int   m;
    logic ok;
    logic s;
    result = 0;
    if (in_bit == seq_prefix_bit(pattern, n, k)) begin
      if (k == n - 1) result = overlap ? seq_failure(pattern, n, n) : 0;
      else            result = k + 1;
    end else begin
      // Longest prefix(j), j <= k, that ends the string prefix(k) followed by in_bit.
      for (int j = 1; j < SEQ_MAX_N; j++) begin
        if (j <= k) begin
          ok = 1'b1;
          for (int i = 0; i < SEQ_MAX_N; i++) begin
            if (i < j) begin
              m = k + 1 - j + i;
              s = (m < k) ? seq_prefix_bit(pattern, n, m) : in_bit;
              if (seq_prefix_bit(pattern, n, i) != s) ok = 1'b0;
            end
          end
          if (ok) result = j;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter: counts inc pulses, sticks at all-ones, cleared
// synchronously by clear or asynchronously by Reset (active low).
module seq_match_counter
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: prefix-length state machine with a
// registered Mealy match pulse and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int           N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter int           OVERLAP = 1,
  parameter int           CNT_W   = 8,
  localparam int          STATE_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               clear,
  input  logic               en,
  input  logic               w,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic [STATE_W-1:0] state
);

  localparam seq_pattern_t         PAT_EXT = seq_pattern_t'(PATTERN);
  localparam logic [STATE_W-1:0]   LAST_K  = STATE_W'(N - 1);
  localparam bit                   OVL     = (OVERLAP != 0);

  logic [STATE_W-1:0] next_tbl [N][2];
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               z_q;
  logic               z_d;
  logic               final_bit;
  seq_event_e         ev;

  // NOTE: the transition table is a set of elaboration-time constants, so it is
  // plain wiring: nothing to store, nothing to reset.
  for (genvar k = 0; k < N; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NEXT_K = seq_next_state(PAT_EXT, N, k, 1'(b), OVL);
      assign next_tbl[k][b] = STATE_W'(NEXT_K);
    end
  end

  // The only way to complete the pattern is holding N-1 bits and seeing the last one.
  assign final_bit = (state_q == LAST_K) && (w == PATTERN[0]);

  // NOTE: every signal driven here gets a default first, so no path through the
  // block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ev      = SEQ_EV_HOLD;
    if (clear) begin
      state_d = '0;
      ev      = SEQ_EV_CLEAR;
    end else if (en) begin
      state_d = next_tbl[state_q][w];
      ev      = final_bit ? SEQ_EV_MATCH : SEQ_EV_STEP;
    end
    z_d = (ev == SEQ_EV_MATCH);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  // The counter sees the same decision as z, so both update on the same edge.
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .Reset (Reset),
    .clear (clear),
    .inc   (z_d),
    .count (match_count)
  );

  assign z     = z_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: six parameter sets on one shared stream, a vector
// table, hand-written corner sequences and a random run against a history model.
module tb_seq_detect_param;

  localparam int ND = 6;

  logic clk = 1'b0;
  logic Reset;
  logic clear;
  logic en;
  logic w;

  always #5 clk = ~clk;

  logic [ND-1:0] z_v;
  logic [7:0]    cnt_v [ND];
  logic [3:0]    st_v  [ND];

  logic [7:0] cnt0, cnt1, cnt2, cnt4, cnt5;
  logic [1:0] cnt3;
  logic [1:0] st0, st1, st2, st3;
  logic       st4;
  logic [3:0] st5;

  seq_detect_param u_d0 (
    .clk(clk), .Reset(Reset), .clear(clear), .en(en), .w(w),
    .z(z_v[0]), .match_count(cnt0), .state(st0));

  seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) u_d1 (
    .clk(clk), .Reset(Reset), .clear(clear), .en(en), .w(w),
    .z(z_v[1]), .match_count(cnt1), .state(st1));

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) u_d2 (
    .clk(clk), .Reset(Reset), .clear(clear), .en(en), .w(w),
    .z(z_v[2]), .match_count(cnt2), .state(st2));

  seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2)) u_d3 (
    .clk(clk), .Reset(Reset), .clear(clear), .en(en), .w(w),
    .z(z_v[3]), .match_count(cnt3), .state(st3));

  seq_detect_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(8)) u_d4 (
    .clk(clk), .Reset(Reset), .clear(clear), .en(en), .w(w),
    .z(z_v[4]), .match_count(cnt4), .state(st4));

  seq_detect_param #(.N(16), .PATTERN(16'hB38F), .OVERLAP(1), .CNT_W(8)) u_d5 (
    .clk(clk), .Reset(Reset), .clear(clear), .en(en), .w(w),
    .z(z_v[5]), .match_count(cnt5), .state(st5));

  assign cnt_v[0] = cnt0;
  assign cnt_v[1] = cnt1;
  assign cnt_v[2] = cnt2;
  assign cnt_v[3] = 8'(cnt3);
  assign cnt_v[4] = cnt4;
  assign cnt_v[5] = cnt5;
  assign st_v[0]  = 4'(st0);
  assign st_v[1]  = 4'(st1);
  assign st_v[2]  = 4'(st2);
  assign st_v[3]  = 4'(st3);
  assign st_v[4]  = 4'(st4);
  assign st_v[5]  = st5;

  int          cfg_n   [ND] = '{3, 3, 4, 3, 2, 16};
  logic [31:0] cfg_pat [ND] = '{32'h5, 32'h5, 32'hD, 32'h5, 32'h3, 32'hB38F};
  int          cfg_ov  [ND] = '{1, 0, 1, 1, 1, 1};
  int          cfg_max [ND] = '{255, 255, 255, 3, 255, 255};

  // Reference model: the consumed bit history since the last restart point.
  logic [31:0] m_hist [ND];
  int          m_len  [ND];
  int          m_cnt  [ND];
  logic        m_z    [ND];

  int n_cmp = 0;
  int n_bad = 0;
  int z3_pulses;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] low_mask(input int j);
    return (32'h1 << j) - 32'h1;
  endfunction

  // Longest pattern prefix (shorter than N) that ends the history.
  function automatic int model_state(input int d);
    int best;
    best = 0;
    for (int j = 1; j < cfg_n[d]; j++) begin
      if (j <= m_len[d] &&
          (m_hist[d] & low_mask(j)) == (cfg_pat[d] >> (cfg_n[d] - j)))
        best = j;
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_hist[d] = '0;
      m_len[d]  = 0;
      m_cnt[d]  = 0;
      m_z[d]    = 1'b0;
    end
  endtask

  task automatic model_step(input logic e, input logic wv, input logic c);
    for (int d = 0; d < ND; d++) begin
      m_z[d] = 1'b0;
      if (c) begin
        m_hist[d] = '0;
        m_len[d]  = 0;
        m_cnt[d]  = 0;
      end else if (e) begin
        m_hist[d] = {m_hist[d][30:0], wv};
        if (m_len[d] < 32) m_len[d]++;
        if (m_len[d] >= cfg_n[d] && (m_hist[d] & low_mask(cfg_n[d])) == cfg_pat[d]) begin
          m_z[d] = 1'b1;
          if (m_cnt[d] < cfg_max[d]) m_cnt[d]++;
          if (cfg_ov[d] == 0) begin
            m_hist[d] = '0;
            m_len[d]  = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic wv, input logic c);
    en    = e;
    w     = wv;
    clear = c;
    @(posedge clk);
    model_step(e, wv, c);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d z", d),     32'(z_v[d]),   32'(m_z[d]));
      check($sformatf("d%0d count", d), 32'(cnt_v[d]), 32'(m_cnt[d]));
      check($sformatf("d%0d state", d), 32'(st_v[d]),  32'(model_state(d)));
    end
    if (z_v[3]) z3_pulses++;
  endtask

  task automatic apply_reset();
    #2 Reset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst d%0d z", d),     32'(z_v[d]),   32'd0);
      check($sformatf("rst d%0d count", d), 32'(cnt_v[d]), 32'd0);
      check($sformatf("rst d%0d state", d), 32'(st_v[d]),  32'd0);
    end
    model_reset();
    @(negedge clk);
    en    = 1'b0;
    clear = 1'b0;
    Reset = 1'b1;
  endtask

  typedef struct {
    logic en;
    logic w;
    logic clr;
    logic z;
    int   cnt;
    int   st;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [15:0] pat5;
    logic [12:0] alt;
    logic        exp_z0 [5];
    logic        exp_z1 [5];
    int          exp_st2 [5];
    int          r;

    Reset = 1'b0;
    clear = 1'b0;
    en    = 1'b0;
    w     = 1'b0;
    model_reset();

    // Default detector (101, overlapping): {en, w, clear} -> {z, count, state}
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 2};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0};

    apply_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, tbl[i].w, tbl[i].clr);
      check($sformatf("tbl[%0d] z", i),     32'(z_v[0]),   32'(tbl[i].z));
      check($sformatf("tbl[%0d] count", i), 32'(cnt_v[0]), 32'(tbl[i].cnt));
      check($sformatf("tbl[%0d] state", i), 32'(st_v[0]),  32'(tbl[i].st));
    end

    // 1,0,1,0,1: overlapping pulses after bits 3 and 5, non-overlapping after bit 3 only.
    exp_z0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_z1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i % 2 == 0), 1'b0);
      check($sformatf("ovl z bit%0d", i + 1),   32'(z_v[0]), 32'(exp_z0[i]));
      check($sformatf("noovl z bit%0d", i + 1), 32'(z_v[1]), 32'(exp_z1[i]));
    end
    check("ovl count",    32'(cnt_v[0]), 32'd2);
    check("noovl count",  32'(cnt_v[1]), 32'd1);
    check("noovl state",  32'(st_v[1]),  32'd1);

    // 1101 on 1,1,1,0,1: states 1,2,2,3 then match back to prefix 1.
    exp_st2 = '{1, 2, 2, 3, 1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i != 3), 1'b0);
      check($sformatf("p1101 state bit%0d", i + 1), 32'(st_v[2]), 32'(exp_st2[i]));
      check($sformatf("p1101 z bit%0d", i + 1),     32'(z_v[2]),  32'(i == 4));
    end

    // 2-bit counter saturates at 3 while z pulses on all 6 matches.
    alt = 13'b1010101010101;
    apply_reset();
    z3_pulses = 0;
    for (int i = 12; i >= 0; i--) step(1'b1, alt[i], 1'b0);
    check("sat count",    32'(cnt_v[3]), 32'd3);
    check("sat z pulses", 32'(z3_pulses), 32'd6);

    // Pattern 11 with overlap: consecutive pulses.
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    check("p11 z bit1", 32'(z_v[4]), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("p11 z bit2", 32'(z_v[4]), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("p11 z bit3", 32'(z_v[4]), 32'd1);
    check("p11 count",  32'(cnt_v[4]), 32'd2);

    // Reset mid-pattern discards the partial match.
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    check("rst-mid z",     32'(z_v[0]),  32'd0);
    check("rst-mid state", 32'(st_v[0]), 32'd1);

    // Clear on the completing edge wins.
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clr-win z",     32'(z_v[0]),   32'd0);
    check("clr-win count", 32'(cnt_v[0]), 32'd0);
    check("clr-win state", 32'(st_v[0]),  32'd0);

    // Random stream, with occasional resets and injected 16-bit patterns.
    pat5 = 16'hB38F;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 999);
      if (r < 5) begin
        apply_reset();
      end else if (r < 25) begin
        for (int i = 15; i >= 0; i--) step(1'b1, pat5[i], 1'b0);
      end else begin
        step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 49) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector for a single-bit input stream. It recognises any fixed bit pattern of length 2..16 using a prefix-length (KMP-style) state machine, in overlapping or non-overlapping mode. It produces a registered Mealy match pulse and a saturating match counter. It replaces the fixed three-bit detectors as the standard pattern-recognition block on serial control lines.

## Interface
Parameters:
- `N`, default 3: pattern length in bits; legal range 2..16.
- `PATTERN`, default 3'b101: pattern bits; `PATTERN[N-1]` is the first bit received and `PATTERN[0]` is the last.
- `OVERLAP`, default 1: 1 allows matches to share bits; 0 restarts from an empty prefix after each match.
- `CNT_W`, default 8: width of the match counter.
- `STATE_W`, localparam: `$clog2(N)`.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `Reset`, input, 1: reset, asynchronous and active-low.
- `clear`, input, 1: synchronous clear of state, `z` and counter; has priority over `en`.
- `en`, input, 1: sample qualifier; `w` is consumed only on edges where `en`=1.
- `w`, input, 1: serial data bit.
- `z`, output, 1: registered match pulse.
- `match_count`, output, CNT_W: number of matches since reset/clear; saturates.
- `state`, output, STATE_W: current matched-prefix length 0..N-1, for debug.

## Operation
- State = length k of the longest pattern prefix equal to a suffix of the consumed bits; k ranges 0..N-1. Reset and clear give state 0.
- On each edge with `en`=1, compare `w` with the expected bit `PATTERN[N-1-k]`:
  - Bit matches, k<N-1: go to k+1, `z`<=0.
  - Bit matches, k=N-1 (full match): `z`<=1 and `match_count` increments.
    - OVERLAP=1: next state = π(N), the longest proper prefix of the pattern that is also a suffix of it.
    - OVERLAP=0: next state = 0.
  - Mismatch: next state = largest j ≤ k such that prefix(j) equals the suffix of (prefix(k) followed by `w`); `z`<=0.
- Edge with `en`=0: state and count hold, `z`<=0.
- Edge with `clear`=1: state 0, `z` 0, count 0, regardless of `en`/`w`.
- `match_count` at all-ones stays at all-ones. `z` still pulses on later matches.
- The transition table is a pure function of `N`/`PATTERN`, evaluated at elaboration; no runtime pattern storage.
- For the default parameters, behaviour is bit-identical to the existing 101 Mealy detector.

## Timing
- Reset values: state 0, `z` 0, `match_count` 0. Reset is asynchronous on assertion, and outputs go low immediately.
- Latency: `z` is high for exactly the one cycle following the edge that sampled the final pattern bit. Back-to-back matches (e.g. OVERLAP=1 with pattern 11) give `z` high on consecutive cycles.
- `match_count` updates on the same edge that sets `z`.
- Reset asserted mid-pattern: the partial match is discarded. After deassertion, detection restarts from k=0.
- Simultaneous `clear` and a completing bit: clear wins, with no pulse and no count.

## Structure
- Shared package `seq_detect_pkg`:
  - Constant `SEQ_MAX_N` = 16.
  - Function `seq_next_state(pattern, n, k, bit, overlap)` returning the prefix length.
  - Function `seq_failure(pattern, n, k)`.
  - The package is reused by future multi-pattern detectors.
- Sub-module `seq_match_counter`: saturating counter with `clk`/`Reset`/`clear`/`inc`/`count`, parametrised by `CNT_W`.

## Test plan
- Default params, OVERLAP=1, `en`=1, w=1,0,1,0,1 → `z` high in cycles after bits 3 and 5; `match_count`=2.
- Default params, OVERLAP=0, same stream → `z` only after bit 3; `match_count`=1; `state`=1 after bit 5.
- N=4, PATTERN=4'b1101, OVERLAP=1, w=1,1,1,0,1 → state sequence 1,2,2,3 then match. `z` after bit 5; state after match = 1.
- Default params, w=1,0 with `en`=1, then `en`=0 for 3 cycles with w toggling, then `en`=1 with w=1 → single `z` pulse after the final sample; no change while `en`=0.
- CNT_W=2, OVERLAP=1, pattern 101, stream 1010101010101 → count stops at 3; `z` still pulses on all 6 matches.
- Reset low after w=1,0, then released and w=1 → no `z`. `clear` on the edge of a completing bit → no `z`, count 0.
